// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   arb_state_e  : arbiter FSM states (idle, granted to m0, granted to m1)
//   WB_OPEN_BUS  : value returned to a master whose transfer the watchdog aborts
//   gnt_onehot() : one-hot grant vector for a given state
package wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  // Wide enough for any practical data bus; users slice the low bits.
  localparam logic [127:0] WB_OPEN_BUS = '1;

  function automatic logic [1:0] gnt_onehot(input arb_state_e s);
    case (s)
      ARB_GNT0: gnt_onehot = 2'b01;
      ARB_GNT1: gnt_onehot = 2'b10;
      default:  gnt_onehot = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Grant watchdog: counts cycles a granted transfer waits without an ack and
// flags the cycle in which the wait limit is reached.
//   clk_i, rst_i : clock, async active-high reset
//   clear_i      : hold the timer at zero (arbiter not granting)
//   run_i        : a granted master is strobing this cycle
//   ack_i        : slave acknowledge this cycle
//   expire_o     : combinational pulse, the current cycle is the abort cycle
// TIMEOUT_CYCLES = 0 disables the watchdog; must be < 65536.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam bit          ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] LIMIT  = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q, timer_d;

  // A real ack in the limit cycle wins, so expiry requires no ack.
  assign expire_o = ENABLE && run_i && !ack_i && (timer_q == LIMIT);

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (run_i && !ack_i) begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter. Master 0 is the CPU bridge,
// master 1 the loader/debug port. One master is granted at a time and the
// grant is held until the slave acks, the master drops its strobe, or the
// watchdog aborts the transfer.
//   m0_*/m1_* : master ports (stb/we/adr/dat in, ack/dat out)
//   s_*       : slave port (stb/we/adr/dat out, ack/dat in)
//   gnt_o     : one-hot grant (00 idle, 01 m0, 10 m1), debug view of the FSM
//   timeout_o : one-cycle pulse on watchdog abort
//   timeout_cnt_o : saturating count of aborts
// Handshake: a master request is stb high; it is complete in the cycle its
// ack is high. Slave signals pass through combinationally while granted, so
// the only added latency is the one-cycle arbitration step in IDLE.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned WB_ADDR_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
  output logic                     m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
  output logic                     m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [WB_ADDR_WIDTH-1:0] s_adr_o,
  output logic [WB_DATA_WIDTH-1:0] s_dat_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_dat_i,
  output logic [1:0]               gnt_o,
  output logic                     timeout_o,
  output logic [7:0]               timeout_cnt_o
);

  localparam logic [WB_DATA_WIDTH-1:0] OPEN_BUS = WB_OPEN_BUS[WB_DATA_WIDTH-1:0];

  arb_state_e state_q, state_d;
  logic       last_q, last_d;          // index of the last master served
  logic [7:0] cnt_q, cnt_d;
  logic                     hold_we_q;
  logic [WB_ADDR_WIDTH-1:0] hold_adr_q;
  logic [WB_DATA_WIDTH-1:0] hold_dat_q;

  logic                     granted, sel1;
  logic                     sel_stb, sel_we;
  logic [WB_ADDR_WIDTH-1:0] sel_adr;
  logic [WB_DATA_WIDTH-1:0] sel_dat;
  logic                     rsp_ack;
  logic [WB_DATA_WIDTH-1:0] rsp_dat;
  logic                     expire;

  assign granted = (state_q == ARB_GNT0) || (state_q == ARB_GNT1);
  assign sel1    = (state_q == ARB_GNT1);
  assign sel_stb = sel1 ? m1_stb_i : m0_stb_i;
  assign sel_we  = sel1 ? m1_we_i  : m0_we_i;
  assign sel_adr = sel1 ? m1_adr_i : m0_adr_i;
  assign sel_dat = sel1 ? m1_dat_i : m0_dat_i;

  // The timer only runs while the granted master is actually strobing; a
  // stb drop is an abort and takes the FSM back to IDLE anyway.
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!granted),
    .run_i   (granted && sel_stb),
    .ack_i   (s_ack_i),
    .expire_o(expire)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_stb_o   = 1'b0;
    s_we_o    = hold_we_q;
    s_adr_o   = hold_adr_q;
    s_dat_o   = hold_dat_q;
    rsp_ack   = 1'b0;
    rsp_dat   = '0;
    timeout_o = 1'b0;

    if (granted) begin
      s_stb_o = sel_stb && !expire;
      s_we_o  = sel_we;
      s_adr_o = sel_adr;
      s_dat_o = sel_dat;
      if (s_ack_i) begin
        // Completion, also when the master drops stb in the same cycle.
        rsp_ack = 1'b1;
        rsp_dat = s_dat_i;
        last_d  = sel1;
        state_d = ARB_IDLE;
      end else if (expire) begin
        rsp_ack   = 1'b1;
        rsp_dat   = OPEN_BUS;
        timeout_o = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        last_d    = sel1;
        state_d   = ARB_IDLE;
      end else if (!sel_stb) begin
        // Master abandoned the transfer: no ack, fairness state untouched.
        state_d = ARB_IDLE;
      end
    end else begin
      if (m0_stb_i && m1_stb_i) begin
        // last_q = 1 means m1 was served last, so m0 wins the tie.
        state_d = ((FIXED_PRIORITY != 0) || last_q) ? ARB_GNT0 : ARB_GNT1;
      end else if (m0_stb_i) begin
        state_d = ARB_GNT0;
      end else if (m1_stb_i) begin
        state_d = ARB_GNT1;
      end
    end

    m0_ack_o = rsp_ack && !sel1;
    m0_dat_o = sel1 ? '0 : rsp_dat;
    m1_ack_o = rsp_ack && sel1;
    m1_dat_o = sel1 ? rsp_dat : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      hold_we_q  <= 1'b0;
      hold_adr_q <= '0;
      hold_dat_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (granted) begin
        hold_we_q  <= sel_we;
        hold_adr_q <= sel_adr;
        hold_dat_q <= sel_dat;
      end
    end
  end

  assign gnt_o         = gnt_onehot(state_q);
  assign timeout_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: two instances share random master/slave stimulus,
// instance 0 round-robin, instance 1 fixed priority, both with an 8-cycle
// watchdog. A transaction-level reference (who holds the bus, who was served
// last, how long the current holder has waited) predicts every output.
module tb_wb_arbiter_2m;

  localparam int TO = 8;
  localparam int N_CYC = 4300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        m0_stb, m0_we, m1_stb, m1_we, s_ack;
  logic [15:0] m0_adr, m1_adr;
  logic [7:0]  m0_dat, m1_dat, s_dat;

  // ---------------- per-instance outputs ----------------
  logic [1:0]       d_m0_ack, d_m1_ack, d_s_stb, d_s_we, d_to;
  logic [1:0][7:0]  d_m0_dat, d_m1_dat, d_s_dat, d_cnt;
  logic [1:0][15:0] d_s_adr;
  logic [1:0][1:0]  d_gnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter_2m #(
      .WB_DATA_WIDTH (8),
      .WB_ADDR_WIDTH (16),
      .TIMEOUT_CYCLES(TO),
      .FIXED_PRIORITY(g)
    ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .m0_stb_i     (m0_stb),
      .m0_we_i      (m0_we),
      .m0_adr_i     (m0_adr),
      .m0_dat_i     (m0_dat),
      .m0_ack_o     (d_m0_ack[g]),
      .m0_dat_o     (d_m0_dat[g]),
      .m1_stb_i     (m1_stb),
      .m1_we_i      (m1_we),
      .m1_adr_i     (m1_adr),
      .m1_dat_i     (m1_dat),
      .m1_ack_o     (d_m1_ack[g]),
      .m1_dat_o     (d_m1_dat[g]),
      .s_stb_o      (d_s_stb[g]),
      .s_we_o       (d_s_we[g]),
      .s_adr_o      (d_s_adr[g]),
      .s_dat_o      (d_s_dat[g]),
      .s_ack_i      (s_ack),
      .s_dat_i      (s_dat),
      .gnt_o        (d_gnt[g]),
      .timeout_o    (d_to[g]),
      .timeout_cnt_o(d_cnt[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody holds the bus, 1 = m0, 2 = m1
  int          owner[2];
  int          last_srv[2];   // master served most recently
  int          wait_cyc[2];   // cycles the owner has waited unacked
  int          n_timeouts[2];
  logic        h_we[2];
  logic [15:0] h_adr[2];
  logic [7:0]  h_dat[2];
  int          rr_m1_wins = 0;  // coverage: round-robin gave a tie to m1

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = 0; last_srv[i] = 1; wait_cyc[i] = 0; n_timeouts[i] = 0;
      h_we[i] = 1'b0; h_adr[i] = '0; h_dat[i] = '0;
    end
  endtask

  task automatic check_inst(input int i, input bit upd);
    logic        e_stb, e_we, e_to;
    logic [15:0] e_adr;
    logic [7:0]  e_dat, e_rdat[2];
    logic        e_ack[2];
    logic [1:0]  e_gnt;
    logic        req_stb, req_we, expired;
    logic [15:0] req_adr;
    logic [7:0]  req_dat;
    int n;
    string p;
    p = $sformatf("i%0d ", i);
    e_stb = 1'b0; e_we = h_we[i]; e_adr = h_adr[i]; e_dat = h_dat[i]; e_to = 1'b0;
    e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_rdat[0] = '0; e_rdat[1] = '0;
    e_gnt = 2'b00; expired = 1'b0; n = 0;
    req_stb = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
    if (owner[i] != 0) begin
      n = owner[i] - 1;
      e_gnt = (n == 0) ? 2'b01 : 2'b10;
      req_stb = n ? m1_stb : m0_stb;
      req_we  = n ? m1_we  : m0_we;
      req_adr = n ? m1_adr : m0_adr;
      req_dat = n ? m1_dat : m0_dat;
      expired = (TO > 0) && req_stb && !s_ack && (wait_cyc[i] == TO - 1);
      e_stb = req_stb && !expired;
      e_we = req_we; e_adr = req_adr; e_dat = req_dat;
      if (s_ack) begin
        e_ack[n] = 1'b1; e_rdat[n] = s_dat;
      end else if (expired) begin
        e_ack[n] = 1'b1; e_rdat[n] = 8'hFF; e_to = 1'b1;
      end
    end
    chk_eq({p, "s_stb"}, d_s_stb[i], e_stb);
    chk_eq({p, "s_we"}, d_s_we[i], e_we);
    chk_eq({p, "s_adr"}, d_s_adr[i], e_adr);
    chk_eq({p, "s_dat"}, d_s_dat[i], e_dat);
    chk_eq({p, "m0_ack"}, d_m0_ack[i], e_ack[0]);
    chk_eq({p, "m0_dat"}, d_m0_dat[i], e_rdat[0]);
    chk_eq({p, "m1_ack"}, d_m1_ack[i], e_ack[1]);
    chk_eq({p, "m1_dat"}, d_m1_dat[i], e_rdat[1]);
    chk_eq({p, "gnt"}, d_gnt[i], e_gnt);
    chk_eq({p, "timeout"}, d_to[i], e_to);
    chk_eq({p, "timeout_cnt"}, d_cnt[i], (n_timeouts[i] > 255) ? 255 : n_timeouts[i]);
    if (!upd) return;
    // advance one clock
    if (owner[i] == 0) begin
      if (m0_stb && m1_stb) begin
        if (i == 1) owner[i] = 1;
        else begin
          owner[i] = (last_srv[i] == 0) ? 2 : 1;
          if (owner[i] == 2) rr_m1_wins++;
        end
      end else if (m0_stb) owner[i] = 1;
      else if (m1_stb) owner[i] = 2;
      wait_cyc[i] = 0;
    end else begin
      h_we[i] = req_we; h_adr[i] = req_adr; h_dat[i] = req_dat;
      if (s_ack) begin
        last_srv[i] = n; owner[i] = 0;
      end else if (expired) begin
        n_timeouts[i]++; last_srv[i] = n; owner[i] = 0;
      end else if (!req_stb) begin
        owner[i] = 0;
      end else begin
        wait_cyc[i]++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int p_ack, input int p_drop, input int p_rise);
    if (m0_stb) begin
      if ($urandom_range(0, 99) < p_drop) m0_stb = 1'b0;
      else if ($urandom_range(0, 99) < 20) begin
        m0_we = 1'($urandom); m0_adr = 16'($urandom); m0_dat = 8'($urandom);
      end
    end else if ($urandom_range(0, 99) < p_rise) begin
      m0_stb = 1'b1; m0_we = 1'($urandom); m0_adr = 16'($urandom); m0_dat = 8'($urandom);
    end
    if (m1_stb) begin
      if ($urandom_range(0, 99) < p_drop) m1_stb = 1'b0;
      else if ($urandom_range(0, 99) < 20) begin
        m1_we = 1'($urandom); m1_adr = 16'($urandom); m1_dat = 8'($urandom);
      end
    end else if ($urandom_range(0, 99) < p_rise) begin
      m1_stb = 1'b1; m1_we = 1'($urandom); m1_adr = 16'($urandom); m1_dat = 8'($urandom);
    end
    s_ack = ($urandom_range(0, 99) < p_ack);
    s_dat = 8'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit rst_done;
    rst_done = 1'b0;
    rst = 1'b1;
    m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
    m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
    s_ack = 0; s_dat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_inst(i, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc >= 1250 && cyc < 1400 && !rst_done && owner[0] == 2) begin
        // async reset in the middle of an m1 grant
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          chk_eq($sformatf("i%0d rst s_stb", i), d_s_stb[i], 1'b0);
          chk_eq($sformatf("i%0d rst gnt", i), d_gnt[i], 2'b00);
          chk_eq($sformatf("i%0d rst m1_ack", i), d_m1_ack[i], 1'b0);
          chk_eq($sformatf("i%0d rst m0_ack", i), d_m0_ack[i], 1'b0);
        end
        model_reset();
        rst_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
      if (cyc == 1400) chk_eq("mid_grant_reset_hit", rst_done, 1'b1);

      if (cyc < 800)       drive(40, 5, 40);
      else if (cyc < 1200) drive(15, 2, 90);
      else if (cyc < 1400) drive(40, 5, 40);
      else if (cyc < 4000) drive(0, 0, 100);
      else                 drive(40, 5, 40);
      #1;
      for (int i = 0; i < 2; i++) check_inst(i, 1'b1);
    end

    chk_eq("rr_tie_to_m1_seen", (rr_m1_wins > 0), 1'b1);
    chk_eq("i0 cnt_saturated", d_cnt[0], 8'hFF);
    chk_eq("i1 cnt_saturated", d_cnt[1], 8'hFF);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
